dmem_responder: RTL

//  Memory-side responder for the single-cycle core's data memory port. Accepts load/store

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_responder_lane_align.sv | 40 ++++
 rtl/dmem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: data width, funct3 access codes, FSM states.
package dmem_responder_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Combinational lane steering: byte enables and replicated store word, plus load lane extract/extend.
// Sub-size address bits are ignored; unknown funct3 codes behave as a full word.
module dmem_responder_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] wd,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] wword,
  output logic [XLEN-1:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{addr_lo, 3'b000} +: 8];
  assign rhalf = rword[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    byte_en   = 4'b1111;
    wword     = wd;
    rdata_ext = rword;
    case (f3)
      F3_B, F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        wword     = {4{wd[7:0]}};
        rdata_ext = (f3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
      end
      F3_H, F3_HU: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword     = {2{wd[15:0]}};
        rdata_ext = (f3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a core load/store, waits LATENCY cycles, then commits the store
// or registers the load result and pulses o_DM_data_ready for one cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          LATENCY   = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [2:0]      i_DM_f3,
  input  logic            i_DM_Wen,
  input  logic            i_DM_MemRead,
  output logic            o_DM_data_ready,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_busy
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [XLEN-1:0] ram [DEPTH];

  state_t          state;
  logic [3:0]      cnt;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wd_q;
  logic [2:0]      f3_q;
  logic            store_q;

  logic             req;
  logic [29:0]      word_off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [3:0]       byte_en;
  logic [XLEN-1:0]  wword;
  logic [XLEN-1:0]  rdata_ext;
  logic             commit;

  assign req      = i_DM_Wen | i_DM_MemRead;
  // Word offset from the base; anything above the index bits means out of range (incl. below base).
  assign word_off = addr_q[31:2] - BASE_ADDR[31:2];
  assign in_range = (word_off >> IDX_W) == 30'd0;
  assign idx      = word_off[IDX_W-1:0];
  assign commit   = (state == S_WAIT) && req && (cnt == 4'd0);

  dmem_responder_lane_align u_lane_align (
    .addr_lo   (addr_q[1:0]),
    .f3        (f3_q),
    .wd        (wd_q),
    .rword     (ram[idx]),
    .byte_en   (byte_en),
    .wword     (wword),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state           <= S_IDLE;
      cnt             <= 4'd0;
      addr_q          <= '0;
      wd_q            <= '0;
      f3_q            <= 3'b000;
      store_q         <= 1'b0;
      o_DM_data_ready <= 1'b0;
      o_DM_ReadData   <= '0;
      o_busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_DM_data_ready <= 1'b0;
          o_DM_ReadData   <= '0;
          if (req) begin
            addr_q  <= i_DM_Addr;
            wd_q    <= i_DM_Wd;
            f3_q    <= i_DM_f3;
            store_q <= i_DM_Wen;
            cnt     <= 4'(LATENCY);
            state   <= S_WAIT;
            o_busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else if (cnt == 4'd0) begin
            state           <= S_RESP;
            o_DM_data_ready <= 1'b1;
            o_DM_ReadData   <= (!store_q && in_range) ? rdata_ext : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state           <= S_IDLE;
          o_DM_data_ready <= 1'b0;
          o_DM_ReadData   <= '0;
          o_busy          <= 1'b0;
        end
      endcase
    end
  end

  // Store lands on the same edge that moves WAIT->RESP; a reset on that edge suppresses it.
  always_ff @(posedge i_clk) begin
    if (i_rst && commit && store_q && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule
